// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave bridging 32-bit transfers onto a single-port synchronous SRAM.
// Adds a programmable number of wait states and gives a two-cycle ERROR response to illegal transfers.
module ahb_sram_slave #(
  parameter int AW          = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSELS,
  input  logic [31:0]   HADDRS,
  input  logic [1:0]    HTRANSS,
  input  logic          HWRITES,
  input  logic [2:0]    HSIZES,
  input  logic          HREADYS,
  input  logic [31:0]   HWDATAS,
  output logic          HREADYOUTS,
  output logic          HRESPS,
  output logic [31:0]   HRDATAS,
  output logic          sram_cs,
  output logic [3:0]    sram_we,
  output logic [AW-3:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {IDLE, RD0, RDW, WRW, WRL, ERR1, ERR2} state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-3:0] waddr_q, waddr_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   rdata_q;
  logic [3:0]    mask_new;
  logic          accept, illegal, rdy;
  logic          unused_bits;

  // Handshake: an address phase is taken only when HSELS, a NONSEQ/SEQ HTRANSS and
  // HREADYS are all high at the rising edge; our data phase ends in the cycle HREADYOUTS=1.
  assign accept  = HSELS & HTRANSS[1] & HREADYS;
  assign illegal = (HSIZES > 3'd2) ||
                   ((HSIZES == 3'd1) && HADDRS[0]) ||
                   ((HSIZES == 3'd2) && (HADDRS[1:0] != 2'b00));
  assign unused_bits = ^{HADDRS[31:AW], HTRANSS[0]};

  always_comb begin
    mask_new = 4'b0000;
    case (HSIZES)
      3'd0:    mask_new = 4'b0001 << HADDRS[1:0];
      3'd1:    mask_new = 4'b0011 << {HADDRS[1], 1'b0};
      default: mask_new = 4'hF;
    endcase
  end

  // Every legal data phase lasts WAIT_STATES+1 cycles: a write spends WAIT_STATES in WRW
  // and commits in WRL; a read spends one cycle in RD0 and WAIT_STATES in RDW.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    mask_d  = mask_q;
    rdy     = 1'b0;
    HRESPS  = 1'b0;
    sram_cs = 1'b0;
    sram_we = 4'b0000;
    case (state_q)
      IDLE: rdy = 1'b1;
      RD0: begin
        sram_cs = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = RDW;
      end
      RDW: begin
        rdy = (cnt_q == 4'd0);
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      WRW: begin
        if (cnt_q == 4'd0) state_d = WRL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WRL: begin
        rdy     = 1'b1;
        sram_cs = 1'b1;
        sram_we = mask_q;
      end
      ERR1: begin
        HRESPS  = 1'b1;
        state_d = ERR2;
      end
      ERR2: begin
        rdy    = 1'b1;
        HRESPS = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // The final data cycle overlaps the next address phase, so pick the next state from it.
    if (rdy) begin
      state_d = IDLE;
      if (accept) begin
        waddr_d = HADDRS[AW-1:2];
        mask_d  = mask_new;
        if (illegal) begin
          state_d = ERR1;
        end else if (HWRITES) begin
          state_d = WRW;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = RD0;
        end
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      waddr_q <= '0;
      mask_q  <= 4'b0000;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      mask_q  <= mask_d;
      if (state_q == RD0) rdata_q <= sram_rdata;
    end
  end

  assign HREADYOUTS = rdy;
  assign HRDATAS    = rdata_q;
  assign sram_addr  = waddr_q;
  assign sram_wdata = HWDATAS;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (1 and 3 wait states) driven by a pipelined AHB master,
// checked by a monitor against a byte-array reference memory and expected-response queues.
module tb_ahb_sram_slave;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit done [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input string detail);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s at %0t", name, detail, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int WS = (g == 0) ? 1 : 3;

    logic          rst_n, hsel, hwrite, hreadyout, hresp, sram_cs;
    logic [31:0]   haddr, hwdata, hrdata, sram_wdata, sram_rdata;
    logic [1:0]    htrans;
    logic [2:0]    hsize, state;
    logic [3:0]    sram_we;
    logic [AW-3:0] sram_addr;

    logic [31:0]   mem     [0:(1<<(AW-2))-1];
    logic [7:0]    ref_mem [0:(1<<AW)-1];
    logic [33:0]   exp_q[$];   // {is_read, is_err, read data}
    logic [AW+33:0] wr_q[$];   // {word addr, byte enables, write data}

    logic        mon_en = 1'b0;
    logic        dp_active = 1'b0;
    int          dp_cycles = 0;
    logic [33:0] cur;
    logic [31:0] last_rd = 32'h0;
    logic [AW+33:0] wexp;

    ahb_sram_slave #(.AW(AW), .WAIT_STATES(WS)) dut (
      .HCLK(clk), .HRESETn(rst_n), .HSELS(hsel), .HADDRS(haddr), .HTRANSS(htrans),
      .HWRITES(hwrite), .HSIZES(hsize), .HREADYS(hreadyout), .HWDATAS(hwdata),
      .HREADYOUTS(hreadyout), .HRESPS(hresp), .HRDATAS(hrdata),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .state_o(state)
    );

    // SRAM model: read data presented for the addressed word, byte writes committed mid-cycle.
    assign sram_rdata = mem[sram_addr];
    initial begin
      for (int i = 0; i < (1 << (AW - 2)); i++) mem[i] = 32'h0;
      forever begin
        @(negedge clk);
        if (sram_cs && sram_we != 4'b0000)
          for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
      end
    end

    always @(negedge clk) begin
      if (!mon_en) begin
        dp_active = 1'b0;
      end else begin
        if (dp_active) begin
          dp_cycles++;
          chk($sformatf("ws%0d_hresp", WS), hresp, cur[32]);
          if (cur[32]) chk($sformatf("ws%0d_err_no_sram", WS), sram_cs, 1'b0);
          if (cur[33] && dp_cycles == 1)
            chk($sformatf("ws%0d_rd0_cs_we", WS), {sram_cs, sram_we}, 5'b10000);
          if (hreadyout) begin
            chk($sformatf("ws%0d_dp_len", WS), dp_cycles, cur[32] ? 2 : WS + 1);
            if (cur[33]) last_rd = cur[31:0];
            chk($sformatf("ws%0d_hrdata", WS), hrdata, last_rd);
            dp_active = 1'b0;
          end else if (dp_cycles > 20) begin
            chk($sformatf("ws%0d_dp_timeout", WS), dp_cycles, WS + 1);
            dp_active = 1'b0;
          end
        end else begin
          chk($sformatf("ws%0d_idle_okay", WS), {hreadyout, hresp}, 2'b10);
        end
        if (hreadyout && hsel && htrans[1]) begin
          if (exp_q.size() == 0) note_fail($sformatf("ws%0d_exp_q", WS), "got empty queue, need an entry");
          else begin
            cur = exp_q.pop_front();
            dp_active = 1'b1;
            dp_cycles = 0;
          end
        end
        if (sram_cs && sram_we != 4'b0000) begin
          if (wr_q.size() == 0) note_fail($sformatf("ws%0d_sram_write", WS), "got a write, none expected");
          else begin
            wexp = wr_q.pop_front();
            chk($sformatf("ws%0d_sram_write", WS), {sram_addr, sram_we, sram_wdata}, wexp);
          end
        end
      end
    end

    task automatic drive_addr(input logic sel, input logic [1:0] trans, input logic wr,
                              input logic [2:0] sz, input logic [31:0] a);
      hsel = sel; htrans = trans; hwrite = wr; hsize = sz; haddr = a;
    endtask

    // Returns just after the edge that takes the currently driven address phase.
    task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!hreadyout && n < 40) begin
        n++;
        @(negedge clk);
      end
      if (!hreadyout) note_fail($sformatf("ws%0d_ready_wait", WS), "got HREADYOUTS stuck 0, need 1");
      @(posedge clk);
      #1;
    endtask

    task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      logic err;
      logic [AW-1:0] base;
      logic [3:0] we;
      logic [31:0] rd;
      int w, lane;
      err  = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
      base = a[AW-1:0];
      w    = int'(base) & ~3;
      we   = 4'b0000;
      if (!err && wr) begin
        for (int b = 0; b < (1 << sz); b++) begin
          lane = int'(base[1:0]) + b;
          we[lane] = 1'b1;
          ref_mem[w + lane] = d[8*lane +: 8];
        end
        wr_q.push_back({base[AW-1:2], we, d});
      end
      rd = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
      exp_q.push_back({!wr && !err, err, (!wr && !err) ? rd : 32'h0});
      drive_addr(1'b1, 2'b10, wr, sz, a);
      wait_ready();
      hwdata = wr ? d : $urandom();
    endtask

    task automatic idle_cycle(input logic sel, input logic [1:0] trans);
      drive_addr(sel, trans, 1'($urandom()), 3'($urandom()), $urandom());
      wait_ready();
      hwdata = $urandom();
    endtask

    task automatic chk_reset(input string name);
      chk(name, {hreadyout, hresp, hrdata, sram_cs, sram_we, sram_addr}, {1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 6'h0});
    endtask

    initial begin
      int r;
      logic [2:0] sz;
      logic [AW-1:0] low;
      logic [31:0] a;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'h00;
      rst_n = 1'b0; hwdata = 32'h0;
      drive_addr(1'b0, 2'b00, 1'b0, 3'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1 chk_reset($sformatf("ws%0d_reset_values", WS));
      rst_n = 1'b1;
      mon_en = 1'b1;
      // Directed: word write/read-back, narrow writes, errors, pipelined accesses.
      xfer(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
      xfer(1'b0, 3'd2, 32'h0000_0010, 32'h0);
      xfer(1'b1, 3'd0, 32'h0000_0013, 32'hAA00_0000);
      xfer(1'b1, 3'd1, 32'h0000_0012, 32'hAA00_0000);
      xfer(1'b0, 3'd2, 32'h0000_0010, 32'h0);
      xfer(1'b0, 3'd1, 32'h0000_0011, 32'h0);
      xfer(1'b1, 3'd2, 32'h0000_0012, 32'h1234_5678);
      xfer(1'b0, 3'd3, 32'h0000_0010, 32'h0);
      xfer(1'b0, 3'd2, 32'h0000_0010, 32'h0);
      idle_cycle(1'b1, 2'b00);
      idle_cycle(1'b0, 2'b10);
      xfer(1'b1, 3'd2, 32'h0000_0020, 32'hCAFE_F00D);
      xfer(1'b0, 3'd2, 32'h0000_0020, 32'h0);
      xfer(1'b1, 3'd2, 32'h0000_0024, 32'h0BAD_C0DE);
      idle_cycle(1'b1, 2'b00);
      // Random mix; upper address bits are noise the slave must ignore.
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 99);
        if (r < 8) idle_cycle(1'b1, 2'(r % 2));
        else if (r < 13) idle_cycle(1'b0, 2'b10);
        else begin
          low = AW'($urandom());
          if (r < 18) sz = 3'($urandom_range(3, 7));
          else if (r < 23) begin
            sz = 3'($urandom_range(1, 2));
            if (sz == 3'd1) low[0] = 1'b1;
            else low[1:0] = 2'($urandom_range(1, 3));
          end else begin
            sz = 3'($urandom_range(0, 2));
            low = low & ~AW'((1 << sz) - 1);
          end
          a = $urandom();
          a[AW-1:0] = low;
          xfer(1'($urandom()), sz, a, $urandom());
        end
      end
      idle_cycle(1'b1, 2'b00);
      idle_cycle(1'b1, 2'b00);
      if (exp_q.size() != 0 || wr_q.size() != 0)
        note_fail($sformatf("ws%0d_drain", WS), $sformatf("got %0d/%0d entries left, need 0/0", exp_q.size(), wr_q.size()));
      // Asynchronous reset in the middle of a read wait phase and of an error response.
      mon_en = 1'b0;
      drive_addr(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0010);
      wait_ready();
      drive_addr(1'b1, 2'b00, 1'b0, 3'd2, 32'h0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset($sformatf("ws%0d_reset_in_rdw", WS));
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive_addr(1'b1, 2'b10, 1'b0, 3'd3, 32'h0000_0010);
      wait_ready();
      drive_addr(1'b1, 2'b00, 1'b0, 3'd2, 32'h0);
      chk($sformatf("ws%0d_err1", WS), {hreadyout, hresp}, 2'b01);
      #2 rst_n = 1'b0;
      #1 chk_reset($sformatf("ws%0d_reset_in_err1", WS));
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("ws%0d_post_reset_idle", WS), {hreadyout, hresp}, 2'b10);
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    wait (done[0] && done[1]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    note_fail("watchdog", "got no completion, need both instances done");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
